video_timing_gen: RTL and testbench

//  Raster timing master for the display path. Generates the HCNT/VCNT pixel

---
 rtl/video_timing_gen.sv | 149 ++++++++++++++
 tb/tb_video_timing_gen.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
// video_timing_gen: raster timing master. Counts HCNT/VCNT, decodes raw
// DE/HS/VS, delays them to meet the returning pixel pipeline, and registers
// the panel outputs.
// Ports: iCLK pixel clock; reset async active-low;
//        iR/iG/iB colour arriving PIPE_DLY clocks after its coordinates;
//        HCNT/VCNT registered coordinates; oFRAME decode of (0,0);
//        oDE/oHS/oVS/oR/oG/oB panel outputs, colour forced to 0 outside DE.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_FP     = 88,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_BP     = 148,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned V_FP     = 4,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 36,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic        iCLK,
    input  logic        reset,
    input  logic [7:0]  iR,
    input  logic [7:0]  iG,
    input  logic [7:0]  iB,
    output logic [11:0] HCNT,
    output logic [10:0] VCNT,
    output logic        oFRAME,
    output logic        oDE,
    output logic        oHS,
    output logic        oVS,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB
);

    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST =
        12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST =
        11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [11:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;

    logic de_r, hs_r, vs_r;

    logic [PIPE_DLY-1:0] de_dly_q, de_dly_d;
    logic [PIPE_DLY-1:0] hs_dly_q, hs_dly_d;
    logic [PIPE_DLY-1:0] vs_dly_q, vs_dly_d;

    logic       de_q, de_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;

    always_comb begin
        hcnt_d = hcnt_q + 12'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = 12'd0;
            if (vcnt_q == V_LAST) begin
                vcnt_d = 11'd0;
            end else begin
                vcnt_d = vcnt_q + 11'd1;
            end
        end
    end

    always_comb begin
        de_r = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs_r = ((hcnt_q >= HS_BEG) && (hcnt_q < HS_END))
               ? HS_POL : ~HS_POL;
        vs_r = ((vcnt_q >= VS_BEG) && (vcnt_q < VS_END))
               ? VS_POL : ~VS_POL;
    end

    // Stage 0 takes the raw decode; the last stage lines up with iR/iG/iB.
    always_comb begin
        de_dly_d    = de_dly_q;
        hs_dly_d    = hs_dly_q;
        vs_dly_d    = vs_dly_q;
        de_dly_d[0] = de_r;
        hs_dly_d[0] = hs_r;
        vs_dly_d[0] = vs_r;
        for (int i = 1; i < int'(PIPE_DLY); i++) begin
            de_dly_d[i] = de_dly_q[i-1];
            hs_dly_d[i] = hs_dly_q[i-1];
            vs_dly_d[i] = vs_dly_q[i-1];
        end
    end

    always_comb begin
        de_d = de_dly_q[PIPE_DLY-1];
        hs_d = hs_dly_q[PIPE_DLY-1];
        vs_d = vs_dly_q[PIPE_DLY-1];
        r_d  = de_d ? iR : 8'h00;
        g_d  = de_d ? iG : 8'h00;
        b_d  = de_d ? iB : 8'h00;
    end

    always_ff @(posedge iCLK or negedge reset) begin
        if (!reset) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            de_dly_q <= '0;
            hs_dly_q <= {PIPE_DLY{~HS_POL}};
            vs_dly_q <= {PIPE_DLY{~VS_POL}};
            de_q     <= 1'b0;
            hs_q     <= ~HS_POL;
            vs_q     <= ~VS_POL;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            de_dly_q <= de_dly_d;
            hs_dly_q <= hs_dly_d;
            vs_dly_q <= vs_dly_d;
            de_q     <= de_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

    assign HCNT   = hcnt_q;
    assign VCNT   = vcnt_q;
    assign oFRAME = (hcnt_q == 12'd0) && (vcnt_q == 11'd0);
    assign oDE    = de_q;
    assign oHS    = hs_q;
    assign oVS    = vs_q;
    assign oR     = r_q;
    assign oG     = g_q;
    assign oB     = b_q;

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
// tb_video_timing_gen: directed table plus raster scans on a default
// 1080p instance and three small-raster instances (PIPE_DLY 1, 2, 4).
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  ir [4];
    logic [7:0]  ig [4];
    logic [7:0]  ib [4];
    logic [11:0] hc [4];
    logic [10:0] vc [4];
    logic        fr [4];
    logic        de [4];
    logic        hs [4];
    logic        vs [4];
    logic [7:0]  orr [4];
    logic [7:0]  og [4];
    logic [7:0]  ob [4];

    video_timing_gen u_d (
        .iCLK(clk), .reset(reset),
        .iR(ir[0]), .iG(ig[0]), .iB(ib[0]),
        .HCNT(hc[0]), .VCNT(vc[0]), .oFRAME(fr[0]),
        .oDE(de[0]), .oHS(hs[0]), .oVS(vs[0]),
        .oR(orr[0]), .oG(og[0]), .oB(ob[0])
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DLY(1)
    ) u_s1 (
        .iCLK(clk), .reset(reset),
        .iR(ir[1]), .iG(ig[1]), .iB(ib[1]),
        .HCNT(hc[1]), .VCNT(vc[1]), .oFRAME(fr[1]),
        .oDE(de[1]), .oHS(hs[1]), .oVS(vs[1]),
        .oR(orr[1]), .oG(og[1]), .oB(ob[1])
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DLY(2)
    ) u_s2 (
        .iCLK(clk), .reset(reset),
        .iR(ir[2]), .iG(ig[2]), .iB(ib[2]),
        .HCNT(hc[2]), .VCNT(vc[2]), .oFRAME(fr[2]),
        .oDE(de[2]), .oHS(hs[2]), .oVS(vs[2]),
        .oR(orr[2]), .oG(og[2]), .oB(ob[2])
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DLY(4)
    ) u_s4 (
        .iCLK(clk), .reset(reset),
        .iR(ir[3]), .iG(ig[3]), .iB(ib[3]),
        .HCNT(hc[3]), .VCNT(vc[3]), .oFRAME(fr[3]),
        .oDE(de[3]), .oHS(hs[3]), .oVS(vs[3]),
        .oR(orr[3]), .oG(og[3]), .oB(ob[3])
    );

    typedef struct {
        int h; int v;
        logic fr; logic de; logic hs; logic vs;
        logic [7:0] r; logic [7:0] g; logic [7:0] b;
    } exp_t;

    typedef struct {
        int k; int h; int v; int fr;
        int de; int hs; int vs; int r;
    } vec_t;

    vec_t tbl [21];

    int errors = 0;
    int checks = 0;
    int k = 0;
    int sess = 0;
    int bad [4] = '{0, 0, 0, 0};
    int first_bad [4] = '{-1, -1, -1, -1};

    int hs_rise1 = -1, hs_rise2 = -1, hs_cnt = 0;
    int de_cnt = 0, gate_bad = 0;
    int vs_rise1 = -1, vs_rise2 = -1, vs_cnt = 0;
    int fr_cnt = 0, fr_k = -1, sde_cnt = 0;
    logic hs0_prev = 1'b0, vs2_prev = 1'b0;

    function automatic int pipe_of(int i);
        case (i)
            1: return 1;
            3: return 4;
            default: return 2;
        endcase
    endfunction

    function automatic exp_t model(int i, int kk);
        exp_t e;
        int ht, vt, ha, h0, h1, va, v0, v1, c, ch, cv;
        if (i == 0) begin
            ht = 2200; vt = 1125; ha = 1920; h0 = 2008;
            h1 = 2052; va = 1080; v0 = 1084; v1 = 1089;
        end else begin
            ht = 16; vt = 8; ha = 8; h0 = 10;
            h1 = 13; va = 4; v0 = 5; v1 = 7;
        end
        e.h  = kk % ht;
        e.v  = (kk / ht) % vt;
        e.fr = (e.h == 0) && (e.v == 0);
        e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
        e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
        c = kk - pipe_of(i) - 1;
        if (c >= 0) begin
            ch = c % ht;
            cv = (c / ht) % vt;
            e.de = (ch < ha) && (cv < va);
            e.hs = (ch >= h0) && (ch < h1);
            e.vs = (cv >= v0) && (cv < v1);
            if (e.de && i == 0) begin
                e.r = 8'hFF; e.g = 8'hFF; e.b = 8'hFF;
            end else if (e.de) begin
                e.r = 8'(ch); e.g = ~8'(ch); e.b = 8'(cv);
            end
        end
        return e;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive();
        int c, ch, cv;
        for (int i = 0; i < 4; i++) begin
            c = k - pipe_of(i);
            if (c < 0) begin
                ir[i] = 8'hEE; ig[i] = 8'hEE; ib[i] = 8'hEE;
            end else if (i == 0) begin
                ir[i] = 8'hFF; ig[i] = 8'hFF; ib[i] = 8'hFF;
            end else begin
                ch = c % 16;
                cv = (c / 16) % 8;
                ir[i] = 8'(ch); ig[i] = ~8'(ch); ib[i] = 8'(cv);
            end
        end
    endtask

    task automatic scan();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e = model(i, k);
            if (int'(hc[i]) != e.h || int'(vc[i]) != e.v ||
                fr[i] !== e.fr || de[i] !== e.de ||
                hs[i] !== e.hs || vs[i] !== e.vs ||
                orr[i] !== e.r || og[i] !== e.g ||
                ob[i] !== e.b) begin
                if (bad[i] == 0) first_bad[i] = k;
                bad[i]++;
            end
        end
        if (sess == 1) begin
            if (hs[0] && !hs0_prev) begin
                if (hs_rise1 < 0) hs_rise1 = k;
                else if (hs_rise2 < 0) hs_rise2 = k;
            end
            hs0_prev = hs[0];
            if (k >= 2011 && k < 4211 && hs[0]) hs_cnt++;
            if (k >= 3 && k < 2203 && de[0]) de_cnt++;
            if (orr[0] !== (de[0] ? 8'hFF : 8'h00) ||
                og[0] !== (de[0] ? 8'hFF : 8'h00) ||
                ob[0] !== (de[0] ? 8'hFF : 8'h00))
                gate_bad++;
            if (vs[2] && !vs2_prev) begin
                if (vs_rise1 < 0) vs_rise1 = k;
                else if (vs_rise2 < 0) vs_rise2 = k;
            end
            vs2_prev = vs[2];
            if (k >= 83 && k < 211 && vs[2]) vs_cnt++;
            if (k >= 1 && k <= 255 && fr[2]) begin
                fr_cnt++;
                if (fr_k < 0) fr_k = k;
            end
            if (k >= 3 && k < 131 && de[2]) sde_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        drive();
        scan();
    endtask

    initial begin
        tbl[0]  = '{0,   0,  0, 1, 0, 0, 0, 0};
        tbl[1]  = '{2,   2,  0, 0, 0, 0, 0, 0};
        tbl[2]  = '{3,   3,  0, 0, 1, 0, 0, 0};
        tbl[3]  = '{4,   4,  0, 0, 1, 0, 0, 1};
        tbl[4]  = '{10,  10, 0, 0, 1, 0, 0, 7};
        tbl[5]  = '{11,  11, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{13,  13, 0, 0, 0, 1, 0, 0};
        tbl[7]  = '{15,  15, 0, 0, 0, 1, 0, 0};
        tbl[8]  = '{16,  0,  1, 0, 0, 0, 0, 0};
        tbl[9]  = '{19,  3,  1, 0, 1, 0, 0, 0};
        tbl[10] = '{20,  4,  1, 0, 1, 0, 0, 1};
        tbl[11] = '{27,  11, 1, 0, 0, 0, 0, 0};
        tbl[12] = '{67,  3,  4, 0, 0, 0, 0, 0};
        tbl[13] = '{83,  3,  5, 0, 0, 0, 1, 0};
        tbl[14] = '{93,  13, 5, 0, 0, 1, 1, 0};
        tbl[15] = '{114, 2,  7, 0, 0, 0, 1, 0};
        tbl[16] = '{115, 3,  7, 0, 0, 0, 0, 0};
        tbl[17] = '{127, 15, 7, 0, 0, 1, 0, 0};
        tbl[18] = '{128, 0,  0, 1, 0, 0, 0, 0};
        tbl[19] = '{131, 3,  0, 0, 1, 0, 0, 0};
        tbl[20] = '{132, 4,  0, 0, 1, 0, 0, 1};

        reset = 1'b0;
        k = 0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_hcnt", int'(hc[i]), 0);
            check("rst_vcnt", int'(vc[i]), 0);
            check("rst_frame", int'(fr[i]), 1);
            check("rst_de", int'(de[i]), 0);
            check("rst_hs", int'(hs[i]), 0);
            check("rst_vs", int'(vs[i]), 0);
            check("rst_r", int'(orr[i]), 0);
        end
        #1 reset = 1'b1;
        sess = 1;

        for (int n = 0; n < 21; n++) begin
            while (k < tbl[n].k) step();
            check("tbl_hcnt", int'(hc[2]), tbl[n].h);
            check("tbl_vcnt", int'(vc[2]), tbl[n].v);
            check("tbl_frame", int'(fr[2]), tbl[n].fr);
            check("tbl_de", int'(de[2]), tbl[n].de);
            check("tbl_hs", int'(hs[2]), tbl[n].hs);
            check("tbl_vs", int'(vs[2]), tbl[n].vs);
            check("tbl_r", int'(orr[2]), tbl[n].r);
        end

        while (k < 13198) step();
        check("d_h2198", int'(hc[0]), 2198);
        check("d_v5a", int'(vc[0]), 5);
        step();
        check("d_h2199", int'(hc[0]), 2199);
        check("d_v5b", int'(vc[0]), 5);
        step();
        check("d_h0", int'(hc[0]), 0);
        check("d_v6", int'(vc[0]), 6);

        check("d_hs_first", hs_rise1, 2011);
        check("d_hs_period", hs_rise2 - hs_rise1, 2200);
        check("d_hs_width", hs_cnt, 44);
        check("d_de_line", de_cnt, 1920);
        check("d_rgb_gate", gate_bad, 0);
        check("s_vs_first", vs_rise1, 83);
        check("s_vs_period", vs_rise2 - vs_rise1, 128);
        check("s_vs_width", vs_cnt, 32);
        check("s_frame_cnt", fr_cnt, 1);
        check("s_frame_k", fr_k, 128);
        check("s_de_frame", sde_cnt, 32);

        sess = 2;
        @(posedge clk);
        #1 reset = 1'b0;
        k = 0;
        drive();
        @(posedge clk);
        #1 reset = 1'b1;
        while (k < 93) step();
        check("pre_hs", int'(hs[2]), 1);
        check("pre_vs", int'(vs[2]), 1);
        check("pre_de_d", int'(de[0]), 1);
        #2 reset = 1'b0;
        #1;
        check("mid_hcnt", int'(hc[2]), 0);
        check("mid_vcnt", int'(vc[2]), 0);
        check("mid_hs", int'(hs[2]), 0);
        check("mid_vs", int'(vs[2]), 0);
        check("mid_frame", int'(fr[2]), 1);
        check("mid_de_d", int'(de[0]), 0);
        check("mid_r_d", int'(orr[0]), 0);
        check("mid_hcnt_d", int'(hc[0]), 0);
        @(posedge clk);
        #1;
        check("hold_hcnt", int'(hc[2]), 0);
        #1 reset = 1'b1;
        k = 0;
        drive();
        step();
        check("rel_hcnt", int'(hc[2]), 1);
        check("rel_de_s1", int'(de[1]), 0);
        step();
        check("rel_de_s1b", int'(de[1]), 1);
        check("rel_de_s2", int'(de[2]), 0);
        step();
        check("rel_de_s2b", int'(de[2]), 1);
        check("rel_de_s4", int'(de[3]), 0);
        step();
        step();
        check("rel_de_s4b", int'(de[3]), 1);
        while (k < 300) step();

        check("scan_d_p2", bad[0], 0);
        check("scan_s_p1", bad[1], 0);
        check("scan_s_p2", bad[2], 0);
        check("scan_s_p4", bad[3], 0);
        for (int i = 0; i < 4; i++) begin
            if (bad[i] != 0)
                $display("  inst %0d first bad cycle %0d",
                         i, first_bad[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
